// File: rtl/counter_issue_ctrl_pkg.sv
// Shared types for the counter issue controller: FSM states, count width, table entry.
// No logic; no latency.
// No flow control.
package counter_issue_ctrl_pkg;

    localparam int CNT_W    = 5;
    // Entry select field is sized for up to 16 PEs; narrower arrays zero-extend.
    localparam int PE_SEL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [PE_SEL_W-1:0] pe_sel;
        logic [CNT_W-1:0]    count;
    } entry_t;

endpackage

// File: rtl/counter_issue_ctrl_table.sv
// Schedule table: DEPTH entries, one synchronous write port, one async read port.
// Write visible the cycle after the strobe; read is combinational.
// No flow control; writes are accepted whenever the strobe is high.
module counter_issue_ctrl_table
    import counter_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
)(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  entry_t        wr_dat,
    input  logic [AW-1:0] rd_addr,
    output entry_t        rd_dat
);

    entry_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/counter_issue_ctrl.sv
// Walks a schedule table, loading one counter_pe at a time and waiting for its expiry flag.
// Issue-to-issue is count+2 cycles; a load strobe is held while the array is stalled.
// Global stall freezes ISSUE/ARM/WAIT; a watchdog aborts a run whose target never expires.
module counter_issue_ctrl
    import counter_issue_ctrl_pkg::*;
#(
    parameter int  N_PE     = 4,
    parameter int  DEPTH    = 8,
    parameter int  WD_LIMIT = 40,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PSW      = (N_PE > 1) ? $clog2(N_PE) : 1
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Global_Stall_I,
    input  logic             Cfg_We_I,
    input  logic [AW-1:0]    Cfg_Addr_I,
    input  logic [PSW+4:0]   Cfg_Data_I,
    input  logic [AW:0]      Num_Entries_I,
    input  logic             Start_I,
    input  logic             Err_Clr_I,
    input  logic [N_PE-1:0]  Clock_Gate_En_I,
    output logic [N_PE-1:0]  Counter_En_O,
    output logic [CNT_W-1:0] Data_Out_O,
    output logic             Busy_O,
    output logic             Done_O,
    output logic             Err_O
);

    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
    localparam logic [5:0]  WD_LIM  = 6'(WD_LIMIT);

    state_t      state;
    logic [AW:0] num_ent;
    logic [AW:0] idx;
    logic [AW:0] idx_inc;
    logic [5:0]  wd;
    logic [5:0]  wd_inc;
    logic        err;

    entry_t          cfg_entry;
    entry_t          cur;
    logic            tbl_we;
    logic [N_PE-1:0] cur_onehot;
    logic            target_flag;
    logic            cfg_err;
    logic            start_err;
    logic            wd_expire;
    logic            err_set;

    always_comb begin
        cfg_entry        = '0;
        cfg_entry.pe_sel = PE_SEL_W'(Cfg_Data_I[CNT_W +: PSW]);
        cfg_entry.count  = Cfg_Data_I[CNT_W-1:0];
    end

    // A zero count would make counter_pe wrap, so such writes are dropped and flagged.
    assign tbl_we  = Cfg_We_I && (state == ST_IDLE) && (cfg_entry.count != '0);
    assign cfg_err = Cfg_We_I && ((state != ST_IDLE) || (cfg_entry.count == '0));

    counter_issue_ctrl_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (tbl_we),
        .wr_addr (Cfg_Addr_I),
        .wr_dat  (cfg_entry),
        .rd_addr (idx[AW-1:0]),
        .rd_dat  (cur)
    );

    assign cur_onehot  = N_PE'(1) << cur.pe_sel;
    assign target_flag = |(Clock_Gate_En_I & cur_onehot);
    assign idx_inc     = idx + 1'b1;
    assign wd_inc      = wd + 1'b1;

    assign start_err = (state == ST_IDLE) && Start_I && (Num_Entries_I > DEPTH_V);
    assign wd_expire = (state == ST_WAIT) && !Global_Stall_I && !target_flag && (wd_inc == WD_LIM);
    assign err_set   = cfg_err || start_err || wd_expire;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            num_ent <= '0;
            idx     <= '0;
            wd      <= '0;
            err     <= 1'b0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end else if (Err_Clr_I) begin
                err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (Start_I) begin
                        if (Num_Entries_I == '0) begin
                            state <= ST_DONE;
                        end else if (Num_Entries_I <= DEPTH_V) begin
                            num_ent <= Num_Entries_I;
                            idx     <= '0;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!Global_Stall_I) begin
                        state <= ST_ARM;
                    end
                end
                // The target still shows its stale flag this cycle, so it is not looked at.
                ST_ARM: begin
                    if (!Global_Stall_I) begin
                        wd    <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!Global_Stall_I) begin
                        if (target_flag) begin
                            idx   <= idx_inc;
                            state <= (idx_inc == num_ent) ? ST_DONE : ST_ISSUE;
                        end else begin
                            wd <= wd_inc;
                            if (wd_expire) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Counter_En_O = (state == ST_ISSUE) ? cur_onehot : '0;
    assign Data_Out_O   = (state == ST_ISSUE) ? cur.count : '0;
    assign Busy_O       = (state != ST_IDLE);
    assign Done_O       = (state == ST_DONE);
    assign Err_O        = err;

endmodule

// File: tb/tb_counter_issue_ctrl.sv
// Directed bench for counter_issue_ctrl with behavioural counter_pe models on each PE.
module tb_counter_issue_ctrl;

    localparam int N_PE  = 4;
    localparam int DEPTH = 8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Global_Stall_I;
    logic       Cfg_We_I;
    logic [2:0] Cfg_Addr_I;
    logic [6:0] Cfg_Data_I;
    logic [3:0] Num_Entries_I;
    logic       Start_I;
    logic       Err_Clr_I;
    logic [3:0] Clock_Gate_En_I;
    logic [3:0] Counter_En_O;
    logic [4:0] Data_Out_O;
    logic       Busy_O;
    logic       Done_O;
    logic       Err_O;

    int vectors = 0;
    int miscompares = 0;

    // run observation results
    int         r_cyc;
    int         r_done;
    int         r_en;
    logic [8:0] loads[$];

    logic       gate_kill = 1'b0;
    logic [4:0] pe_cnt [N_PE];

    always #5 Clk = ~Clk;

    counter_issue_ctrl #(
        .N_PE     (N_PE),
        .DEPTH    (DEPTH),
        .WD_LIMIT (40)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Global_Stall_I  (Global_Stall_I),
        .Cfg_We_I        (Cfg_We_I),
        .Cfg_Addr_I      (Cfg_Addr_I),
        .Cfg_Data_I      (Cfg_Data_I),
        .Num_Entries_I   (Num_Entries_I),
        .Start_I         (Start_I),
        .Err_Clr_I       (Err_Clr_I),
        .Clock_Gate_En_I (Clock_Gate_En_I),
        .Counter_En_O    (Counter_En_O),
        .Data_Out_O      (Data_Out_O),
        .Busy_O          (Busy_O),
        .Done_O          (Done_O),
        .Err_O           (Err_O)
    );

    // Behavioural counter_pe: load on strobe, count down when not stalled, flag at zero.
    always @(posedge Clk) begin
        for (int i = 0; i < N_PE; i++) begin
            if (Reset) pe_cnt[i] <= '0;
            else if (Counter_En_O[i]) pe_cnt[i] <= Data_Out_O;
            else if (!Global_Stall_I && pe_cnt[i] != 0) pe_cnt[i] <= pe_cnt[i] - 5'd1;
        end
    end

    always_comb begin
        Clock_Gate_En_I = '0;
        for (int i = 0; i < N_PE; i++) begin
            Clock_Gate_En_I[i] = (pe_cnt[i] == 5'd0) && !gate_kill;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [1:0] pe, input logic [4:0] cnt);
        Cfg_We_I   = 1'b1;
        Cfg_Addr_I = addr;
        Cfg_Data_I = {pe, cnt};
        step();
        Cfg_We_I   = 1'b0;
    endtask

    task automatic start(input logic [3:0] n);
        Start_I       = 1'b1;
        Num_Entries_I = n;
        step();
        Start_I       = 1'b0;
    endtask

    task automatic clear_err();
        Err_Clr_I = 1'b1;
        step();
        Err_Clr_I = 1'b0;
    endtask

    // Steps until Busy_O drops, recording distinct loads, strobe cycles and Done pulses.
    task automatic run_until_idle(input int budget);
        logic [3:0] prev;
        prev   = '0;
        r_cyc  = 0;
        r_done = 0;
        r_en   = 0;
        loads.delete();
        while (Busy_O && r_cyc < budget) begin
            if (Counter_En_O != 0) begin
                r_en++;
                if (prev == 0) loads.push_back({Counter_En_O, Data_Out_O});
            end
            if (Done_O) r_done++;
            prev = Counter_En_O;
            step();
            r_cyc++;
        end
        chk("run_timeout_busy", {31'd0, Busy_O}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset          = 1'b1;
        Global_Stall_I = 1'b0;
        Cfg_We_I       = 1'b0;
        Cfg_Addr_I     = '0;
        Cfg_Data_I     = '0;
        Num_Entries_I  = '0;
        Start_I        = 1'b0;
        Err_Clr_I      = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, Busy_O}, 32'd0);
        chk("rst_done", {31'd0, Done_O}, 32'd0);
        chk("rst_err",  {31'd0, Err_O},  32'd0);
        chk("rst_en",   {28'd0, Counter_En_O}, 32'd0);
        chk("rst_data", {27'd0, Data_Out_O},   32'd0);
        Reset = 1'b0;
        step();

        // Single entry {pe1,3}
        cfg_write(3'd0, 2'd1, 5'd3);
        start(4'd1);
        chk("t1_issue_en",   {28'd0, Counter_En_O}, 32'h2);
        chk("t1_issue_data", {27'd0, Data_Out_O},   32'd3);
        chk("t1_issue_busy", {31'd0, Busy_O},       32'd1);
        run_until_idle(60);
        chk("t1_cycles", r_cyc,  6);
        chk("t1_done",   r_done, 1);
        chk("t1_en_cyc", r_en,   1);
        chk("t1_err",    {31'd0, Err_O}, 32'd0);

        // Three-entry schedule
        cfg_write(3'd0, 2'd0, 5'd2);
        cfg_write(3'd1, 2'd3, 5'd5);
        cfg_write(3'd2, 2'd2, 5'd1);
        start(4'd3);
        run_until_idle(100);
        chk("t2_nloads", loads.size(), 3);
        chk("t2_load0",  {23'd0, loads[0]}, {23'd0, 4'b0001, 5'd2});
        chk("t2_load1",  {23'd0, loads[1]}, {23'd0, 4'b1000, 5'd5});
        chk("t2_load2",  {23'd0, loads[2]}, {23'd0, 4'b0100, 5'd1});
        chk("t2_done",   r_done, 1);
        chk("t2_cycles", r_cyc,  15);
        chk("t2_err",    {31'd0, Err_O}, 32'd0);

        // Stall held four cycles in ISSUE
        start(4'd1);
        Global_Stall_I = 1'b1;
        repeat (4) step();
        chk("t3_hold_en",   {28'd0, Counter_En_O}, 32'h1);
        chk("t3_hold_data", {27'd0, Data_Out_O},   32'd2);
        Global_Stall_I = 1'b0;
        run_until_idle(60);
        chk("t3_nloads", loads.size(), 1);
        chk("t3_en_cyc", r_en,   1);
        chk("t3_cycles", r_cyc,  5);
        chk("t3_done",   r_done, 1);

        // Config errors
        cfg_write(3'd0, 2'd1, 5'd0);
        chk("t4_zero_err", {31'd0, Err_O}, 32'd1);
        Err_Clr_I = 1'b1;
        cfg_write(3'd0, 2'd1, 5'd0);
        chk("t4_set_wins", {31'd0, Err_O}, 32'd1);
        step();
        Err_Clr_I = 1'b0;
        chk("t4_clr", {31'd0, Err_O}, 32'd0);
        start(4'd1);
        cfg_write(3'd0, 2'd3, 5'd7);
        chk("t4_busy_err", {31'd0, Err_O}, 32'd1);
        run_until_idle(60);
        chk("t4_busy_done", r_done, 1);
        clear_err();
        chk("t4_clr2", {31'd0, Err_O}, 32'd0);
        start(4'd1);
        run_until_idle(60);
        chk("t4_entry_kept", {23'd0, loads[0]}, {23'd0, 4'b0001, 5'd2});

        // Too many entries requested
        start(4'd9);
        chk("t5_ovf_err",  {31'd0, Err_O},  32'd1);
        chk("t5_ovf_busy", {31'd0, Busy_O}, 32'd0);
        clear_err();

        // Watchdog abort
        gate_kill = 1'b1;
        start(4'd1);
        run_until_idle(100);
        chk("t6_cycles", r_cyc,  42);
        chk("t6_done",   r_done, 0);
        chk("t6_err",    {31'd0, Err_O}, 32'd1);
        gate_kill = 1'b0;

        // Reset mid-WAIT (Err_O still set from the watchdog)
        start(4'd1);
        step();
        step();
        chk("t7_in_wait", {31'd0, Busy_O}, 32'd1);
        Reset = 1'b1;
        step();
        chk("t7_busy", {31'd0, Busy_O}, 32'd0);
        chk("t7_en",   {28'd0, Counter_En_O}, 32'd0);
        chk("t7_data", {27'd0, Data_Out_O},   32'd0);
        chk("t7_done", {31'd0, Done_O}, 32'd0);
        chk("t7_err",  {31'd0, Err_O},  32'd0);
        Reset = 1'b0;
        step();
        step();
        chk("t7_no_done", {31'd0, Done_O}, 32'd0);
        start(4'd0);
        chk("t7_n0_done", {31'd0, Done_O}, 32'd1);
        step();
        chk("t7_n0_pulse", {31'd0, Done_O}, 32'd0);
        chk("t7_n0_idle",  {31'd0, Busy_O}, 32'd0);
        start(4'd1);
        chk("t7_tbl_en",   {28'd0, Counter_En_O}, 32'h1);
        chk("t7_tbl_data", {27'd0, Data_Out_O},   32'd0);
        run_until_idle(60);
        chk("t7_tbl_done", r_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
